int_to_half_conv: RTL and testbench
===================================

Name: int_to_half_conv

Overview:
- Memory-mapped converter: a 16-bit two's-complement integer in its internal data memory becomes a 16-bit half-precision float (1 sign, 5 exponent bias 15, 10 fraction, hidden 1).
- Operand low byte at mem[0], high byte at mem[1].
- Result written low byte to mem[2], high byte to mem[3].
- Controlled by a start/done handshake; the bench loads and reads memory hierarchically.

Parameters:
- MEM_DEPTH, 256, number of byte locations in internal data memory.
- EXP_BIAS, 15, exponent bias.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- start  input  1  request; conversion begins on first rising edge sampling start=0 after start=1
- done  output  1  result valid in mem[3:2]; level, held until next start

Behaviour:
- Internal memory instance named data_mem1, byte array mem_core[MEM_DEPTH]. It is directly writable and readable hierarchically; it is not cleared by reset.
- Reset (reset=0 at a clk edge):
  - FSM goes to IDLE.
  - done=0.
- FSM states:
  - IDLE: wait for start=1. Go to ARMED.
  - ARMED: done=0 while start=1. On start=0, go to READ.
  - READ: latch {mem[1],mem[0]}.
  - CONV: compute the result.
  - WRITE: store mem[2]=res[7:0], mem[3]=res[15:8].
  - DONE: done=1. On start=1, go to ARMED (done=0).
- Latency: done=1 no later than the 4th rising edge after start is first sampled low; memory write completes on or before the edge that raises done.
- start re-asserted mid-conversion: abort, return to ARMED, done=0.
- Conversion:
  - sign = in[15].
  - mag = sign ? -in : in (16-bit).
  - in==0x0000: result 0x0000.
  - in==0x8000: result 0xF800 (sign 1, exp 30, frac 0).
  - Otherwise, p = index of leading 1 of mag[14:0], exp = p+15.
  - p<=10: frac = mag bits below p, left-justified and zero-padded.
  - p>10: take 11 bits mag[p:p-10]; L = mag[p-10], R = mag[p-11], S = OR of mag[p-12:0] (0 if none).
  - Round-to-nearest-even: add 1 if R & (L|S).
  - Carry out of 11 bits: exp+1, frac=0.
  - Max exp produced is 30; no infinity or denormals.

Optional Feature:
- Macro INT2FLT_ROUND_EN.
- Defined: round-to-nearest-even as above (required configuration for conformance benches).
- Undefined: truncate (R/S ignored, never increments). All other behaviour identical.

Decomposition:
- Package int2flt_pkg:
  - state enum (IDLE, ARMED, READ, CONV, WRITE, DONE).
  - address constants ADDR_IN_LO=0, ADDR_IN_HI=1, ADDR_OUT_LO=2, ADDR_OUT_HI=3.
  - EXP_BIAS, half-float field widths.
- Sub-module data_mem: single-port byte RAM, write-enable, combinational read.
- Conversion is a combinational function in the top.

Test Plan:
- For each case, load mem[1:0], pulse start 2 cycles, then wait for done.
- in=1 -> 0x3C00; in=3 -> 0x4200; in=0 -> 0x0000.
- in=-1 (0xFFFF) -> 0xBC00; in=0x8000 -> 0xF800; in=-48 -> 0xD200.
- Rounding:
  - in=8191 -> 0x7000 (mantissa overflow bumps exponent).
  - in=30767 -> 0x7783.
  - in=32767 -> 0x7800.
- Ties:
  - in=2049 -> 0x6800 (round down to even).
  - in=2051 -> 0x6802 (round up to even).
- Handshake:
  - done=0 while start=1.
  - done=1 within 4 edges of start falling, and stays 1.
  - reset=0 mid-conversion -> done=0, IDLE.
  - Randomised ~70 operands checked against a software model, exact 16-bit match.

Source files
------------

// File: rtl/int_to_half_conv_pkg.sv
// int2flt_pkg: shared FSM states, memory map and half-float field widths.
package int2flt_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, READ, CONV, WRITE, DONE} state_t;
  localparam int ADDR_IN_LO = 0;
  localparam int ADDR_IN_HI = 1;
  localparam int ADDR_OUT_LO = 2;
  localparam int ADDR_OUT_HI = 3;
  localparam int EXP_BIAS = 15;
  localparam int EXP_W = 5;
  localparam int FRAC_W = 10;
endpackage

// File: rtl/int_to_half_conv_if.sv
// int_to_half_conv_if: start/done handshake bundle.
//   start - request, driven by master
//   done  - result valid level, driven by slave
interface int_to_half_conv_if;
  logic start;
  logic done;
  modport master(output start, input done);
  modport slave(input start, output done);
endinterface

// File: rtl/int_to_half_conv_data_mem.sv
// data_mem: single-port byte RAM with halfword access at addr/addr+1.
//   clk   - write clock
//   addr  - byte address of the low byte
//   we    - writes wdata[7:0] to addr and wdata[15:8] to addr+1
//   wdata - halfword to store
//   rdata - combinational {mem[addr+1], mem[addr]}
module data_mem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [15:0]              wdata,
  output logic [15:0]              rdata
);
  logic [7:0] mem_core [DEPTH];
  logic [$clog2(DEPTH)-1:0] addr_hi;
  assign addr_hi = addr + 1'b1;
  assign rdata = {mem_core[addr_hi], mem_core[addr]};
  always_ff @(posedge clk) begin
    if (we) begin
      mem_core[addr] <= wdata[7:0];
      mem_core[addr_hi] <= wdata[15:8];
    end
  end
endmodule

// File: rtl/int_to_half_conv.sv
// int_to_half_conv: converts the int16 at mem[1:0] to a half float at mem[3:2].
//   clk   - rising-edge clock
//   reset - synchronous active-low reset
//   bus   - slave side of start/done handshake
// Optional macro INT2FLT_ROUND_EN: round-to-nearest-even; truncation otherwise.
module int_to_half_conv #(
  parameter int MEM_DEPTH = 256,
  parameter int EXP_BIAS = 15
) (
  input logic clk,
  input logic reset,
  int_to_half_conv_if.slave bus
);
  import int2flt_pkg::*;
  localparam int AW = $clog2(MEM_DEPTH);
  state_t state;
  logic [15:0] op;
  logic [15:0] res;
  logic [15:0] rdata;
  logic [AW-1:0] addr;
  logic we;
  // Normalise so the leading one falls off the top; the next 10 bits are the
  // fraction and the 4 below them supply the round/sticky information.
  function automatic logic [15:0] to_half(input logic [15:0] in);
    logic [15:0] mag;
    logic [3:0] p;
    logic [9:0] frac;
    logic inc;
    logic [10:0] sum;
    logic [4:0] e;
`ifdef INT2FLT_ROUND_EN
    logic [3:0] grs;
`endif
    mag = in[15] ? 16'(-in) : in;
    p = '0;
    for (int i = 0; i < 16; i++) if (mag[i]) p = 4'(i);
`ifdef INT2FLT_ROUND_EN
    {frac, grs} = 14'(mag[14:0] << (4'd14 - p));
    inc = grs[3] & (frac[0] | (|grs[2:0]));
`else
    frac = 10'((mag[14:0] << (4'd14 - p)) >> 4);
    inc = 1'b0;
`endif
    sum = {1'b0, frac} + 11'(inc);
    e = 5'(p) + 5'(EXP_BIAS) + 5'(sum[10]);
    to_half = in == 16'h0000 ? 16'h0000 :
              in == 16'h8000 ? 16'hF800 :
              {in[15], e, sum[10] ? 10'd0 : sum[9:0]};
  endfunction
  assign addr = state == WRITE ? AW'(ADDR_OUT_LO) : AW'(ADDR_IN_LO);
  assign we = state == WRITE && !bus.start;
  data_mem #(.DEPTH(MEM_DEPTH)) data_mem1 (
    .clk(clk),
    .addr(addr),
    .we(we),
    .wdata(res),
    .rdata(rdata)
  );
  // Any start=1 while busy aborts back to ARMED; done only rises from WRITE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= bus.start ? ARMED : IDLE;
        ARMED: state <= bus.start ? ARMED : READ;
        READ: begin
          op <= rdata;
          state <= bus.start ? ARMED : CONV;
        end
        CONV: begin
          res <= to_half(op);
          state <= bus.start ? ARMED : WRITE;
        end
        WRITE: begin
          state <= bus.start ? ARMED : DONE;
          bus.done <= !bus.start;
        end
        DONE: begin
          state <= bus.start ? ARMED : DONE;
          bus.done <= !bus.start;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_to_half_conv.sv
// tb_int_to_half_conv: scoreboard bench for int_to_half_conv.
module tb_int_to_half_conv;
  import int2flt_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] vin[11];
  logic [15:0] vexp[11];
  int_to_half_conv_if bus();
  int_to_half_conv dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  function automatic logic [15:0] model(input logic [15:0] v);
    int x, m, p, e, q, sh;
`ifdef INT2FLT_ROUND_EN
    int rem, half;
`endif
    x = $signed(v);
    if (x == 0) return 16'h0000;
    if (x == -32768) return 16'hF800;
    m = x < 0 ? -x : x;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = p + 15;
    if (p <= 10) q = m << (10 - p);
    else begin
      sh = p - 10;
      q = m >> sh;
`ifdef INT2FLT_ROUND_EN
      rem = m - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && q % 2 == 1)) q++;
`endif
      if (q == 2048) begin
        q = 1024;
        e++;
      end
    end
    return {x < 0, 5'(e), 10'(q - 1024)};
  endfunction
  task automatic run_case(input logic [15:0] v, input logic [15:0] expv);
    int n;
    @(negedge clk);
    dut.data_mem1.mem_core[0] = v[7:0];
    dut.data_mem1.mem_core[1] = v[15:8];
    exp_q.push_back(expv);
    bus.start = 1'b1;
    @(negedge clk);
    check("done_low_start1", 16'(bus.done), 16'h0);
    @(negedge clk);
    check("done_low_start2", 16'(bus.done), 16'h0);
    bus.start = 1'b0;
    n = 0;
    while (n < 4 && !bus.done) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", 16'(bus.done), 16'h1);
    repeat (2) @(negedge clk);
    check("done_held", 16'(bus.done), 16'h1);
  endtask
  initial begin : monitor
    logic prev;
    logic [15:0] req;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !prev) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done actual=%h required=none",
                   {dut.data_mem1.mem_core[3], dut.data_mem1.mem_core[2]});
        end else begin
          req = exp_q.pop_front();
          check("result", {dut.data_mem1.mem_core[3], dut.data_mem1.mem_core[2]}, req);
        end
      end
      prev = bus.done;
    end
  end
  initial begin
    logic [15:0] v;
    bus.start = 1'b0;
    vin = '{16'h0001, 16'h0003, 16'h0000, 16'hFFFF, 16'h8000, 16'hFFD0,
            16'd8191, 16'd30767, 16'd32767, 16'd2049, 16'd2051};
`ifdef INT2FLT_ROUND_EN
    vexp = '{16'h3C00, 16'h4200, 16'h0000, 16'hBC00, 16'hF800, 16'hD200,
             16'h7000, 16'h7783, 16'h7800, 16'h6800, 16'h6802};
`else
    vexp = '{16'h3C00, 16'h4200, 16'h0000, 16'hBC00, 16'hF800, 16'hD200,
             16'h6FFF, 16'h7782, 16'h77FF, 16'h6800, 16'h6801};
`endif
    repeat (2) @(negedge clk);
    check("reset_done", 16'(bus.done), 16'h0);
    check("reset_state", 16'(dut.state), 16'(IDLE));
    reset = 1'b1;
    for (int i = 0; i < 11; i++) run_case(vin[i], vexp[i]);
    @(negedge clk);
    dut.data_mem1.mem_core[0] = 8'h34;
    dut.data_mem1.mem_core[1] = 8'h12;
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_done", 16'(bus.done), 16'h0);
    check("midreset_state", 16'(dut.state), 16'(IDLE));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_stays_idle", 16'(dut.state), 16'(IDLE));
    for (int i = 0; i < 70; i++) begin
      v = 16'($urandom);
      run_case(v, model(v));
    end
    repeat (2) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
